counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
Controller that sequences a WIDTH-bit up-counter for the counter datapath (the JK-based synchronous counter family). It accepts commands over a valid/ready port: start, stop, load terminal value, clear. It applies a programmable prescaler to generate count ticks. It reports terminal count in either one-shot or auto-reload mode. It sits between a host/control FSM and the count register it owns.

Parameters:
WIDTH, 4, count and terminal-value width
PRESCALE_W, 4, prescaler field width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command can be accepted this cycle
cmd_op  input  2  00 START, 01 STOP, 10 LOAD, 11 CLEAR
cmd_data  input  WIDTH  terminal value for LOAD; ignored otherwise
cmd_mode  input  1  sampled on START: 0 one-shot, 1 auto-reload
cmd_prescale  input  PRESCALE_W  sampled on START: ticks every cmd_prescale+1 cycles
q  output  WIDTH  current count
busy  output  1  high in RUN
holding  output  1  high in HOLD
done  output  1  one-cycle pulse on terminal count

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset). All outputs are registered except cmd_ready, which decodes from state.
- Command accepted on a rising edge where cmd_valid && cmd_ready. cmd_ready = 0 only in FLUSH.
- Reset values: state IDLE, q=0, limit=all ones, ps=0, mode=0, pcnt=0, done=0, busy=0, holding=0, cmd_ready=1.
- States:
  - IDLE
  - RUN
  - HOLD
  - FLUSH (1 cycle)
- START:
  - From IDLE: q<=0, pcnt<=0, latch mode/ps, go to RUN.
  - From HOLD: resume with q and pcnt kept; relatch mode/ps; go to RUN.
  - In RUN: accepted, no effect.
- STOP:
  - RUN -> HOLD, with q and pcnt frozen.
  - In IDLE or HOLD: accepted, no effect.
- LOAD: limit<=cmd_data in any state except FLUSH. The state does not change.
- CLEAR: from any state -> FLUSH. q<=0, pcnt<=0, done<=0. FLUSH -> IDLE unconditionally next cycle.
- Tick (RUN only): tick = (pcnt==ps).
  - On a tick, pcnt<=0; otherwise pcnt<=pcnt+1.
  - ps=0 gives a tick every RUN cycle.
- On a tick:
  - If q >= limit (terminal): done<=1 for exactly one cycle.
    - One-shot: q holds, state -> IDLE.
    - Auto-reload: q<=0, stay in RUN.
  - Else q<=q+1. Arithmetic is WIDTH-bit unsigned, no overflow possible since q never exceeds limit except after a LOAD.
  - The >= compare makes a LOAD below the current q terminate at the next tick.
- Timing: with START accepted at edge E0, the first tick-eligible edge is E1.
  - One-shot: done is asserted after edge E(limit+1)*(ps+1) and final q=limit.
  - Auto-reload: period = (limit+1)*(ps+1) cycles.
- Simultaneous events:
  - CLEAR beats everything; it suppresses done and the tick.
  - STOP on a tick edge: the tick's update applies first, then HOLD. If that tick was terminal in one-shot, the state goes to IDLE and done still pulses.
  - LOAD on a tick edge: the compare uses the old limit; the new limit applies from the next cycle.
  - START in RUN on a terminal auto-reload tick: the reload proceeds normally.
- limit=0: every tick is terminal. One-shot ends at the first tick with q=0. Auto-reload pulses done every ps+1 cycles.
- Reset mid-operation: returns to the reset values at the next edge regardless of state or command.

Test Plan:
- Reset, LOAD 3, START one-shot ps=0 -> q 1,2,3 on E1..E3; done=1 exactly one cycle after E4; q=3; busy=0 afterwards.
- LOAD 2, START auto-reload ps=1 -> q advances every 2 cycles 0,1,2,0,...; done pulses every 6 cycles; busy stays 1.
- Run with limit 15, ps=0; STOP at q=5 -> holding=1, q=5 frozen for 10 cycles; START -> resumes to 6 next edge; done after q=15 terminal tick.
- CLEAR while RUN at q=7 -> next cycle q=0 and cmd_ready=0; cycle after that cmd_ready=1 in IDLE; no done pulse.
- In RUN at q=9, LOAD 4 -> terminal at next tick; done pulses; one-shot ends in IDLE with q=9.
- Assert reset during RUN with done pending -> all outputs at reset values next edge; limit reads back as 15 (next START counts to 15).

Source files
------------

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for a WIDTH-bit up-counter with a programmable prescaler and
// one-shot / auto-reload terminal count reporting.
module counter_sequencer #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_data,
  input  logic                  cmd_mode,
  input  logic [PRESCALE_W-1:0] cmd_prescale,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic                  holding,
  output logic                  done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;
  localparam logic [1:0] StFlush = 2'd3;

  localparam logic [1:0] OpStart = 2'b00;
  localparam logic [1:0] OpStop  = 2'b01;
  localparam logic [1:0] OpLoad  = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  logic [1:0]            state_q, state_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic [WIDTH-1:0]      limit_q, limit_d;
  logic [PRESCALE_W-1:0] ps_q, ps_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  mode_q, mode_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  holding_q, holding_d;
  logic                  accept;
  logic                  tick;

  assign cmd_ready = (state_q != StFlush);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (state_q == StRun) && (pcnt_q == ps_q);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    limit_d = limit_q;
    ps_d    = ps_q;
    mode_d  = mode_q;
    pcnt_d  = pcnt_q;
    done_d  = 1'b0;

    // Prescaler and count update; commands below may override.
    if (state_q == StRun) begin
      if (tick) begin
        pcnt_d = '0;
        if (q_q >= limit_q) begin
          done_d = 1'b1;
          if (mode_q) begin
            q_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end

    if (state_q == StFlush) begin
      state_d = StIdle;
    end

    if (accept) begin
      unique case (cmd_op)
        OpStart: begin
          if (state_q == StIdle) begin
            q_d     = '0;
            pcnt_d  = '0;
            mode_d  = cmd_mode;
            ps_d    = cmd_prescale;
            state_d = StRun;
          end else if (state_q == StHold) begin
            mode_d  = cmd_mode;
            ps_d    = cmd_prescale;
            state_d = StRun;
          end
        end
        OpStop: begin
          // A terminal one-shot tick on the same edge has already sent us to IDLE.
          if (state_q == StRun && state_d == StRun) begin
            state_d = StHold;
          end
        end
        OpLoad: begin
          limit_d = cmd_data;
        end
        OpClear: begin
          state_d = StFlush;
          q_d     = '0;
          pcnt_d  = '0;
          done_d  = 1'b0;
        end
        default: ;
      endcase
    end

    busy_d    = (state_d == StRun);
    holding_d = (state_d == StHold);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      q_q       <= '0;
      limit_q   <= '1;
      ps_q      <= '0;
      mode_q    <= 1'b0;
      pcnt_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      holding_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      limit_q   <= limit_d;
      ps_q      <= ps_d;
      mode_q    <= mode_d;
      pcnt_q    <= pcnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      holding_q <= holding_d;
    end
  end

  assign q       = q_q;
  assign busy    = busy_q;
  assign holding = holding_q;
  assign done    = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed scoreboard bench for counter_sequencer: each step queues the outputs expected
// after the next edge, and they are popped and checked #1 after that edge.
module tb_counter_sequencer;

  localparam logic [1:0] OpStart = 2'b00;
  localparam logic [1:0] OpStop  = 2'b01;
  localparam logic [1:0] OpLoad  = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       cmd_mode;
  logic [3:0] cmd_prescale;
  logic [3:0] q;
  logic       busy;
  logic       holding;
  logic       done;

  typedef struct {
    string      tag;
    logic [3:0] q;
    logic       busy;
    logic       holding;
    logic       done;
    logic       ready;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  counter_sequencer #(
    .WIDTH      (4),
    .PRESCALE_W (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_mode     (cmd_mode),
    .cmd_prescale (cmd_prescale),
    .q            (q),
    .busy         (busy),
    .holding      (holding),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input string field, input logic [3:0] act,
                       input logic [3:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the edge.
  task automatic step(input string tag, input logic v, input logic [1:0] op,
                      input logic [3:0] d, input logic m, input logic [3:0] p,
                      input logic [3:0] eq, input logic eb, input logic eh,
                      input logic edn, input logic er);
    exp_t e;
    cmd_valid    = v;
    cmd_op       = op;
    cmd_data     = d;
    cmd_mode     = m;
    cmd_prescale = p;
    sb.push_back('{tag, eq, eb, eh, edn, er});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.tag, "q",       q,                 e.q);
    check(e.tag, "busy",    {3'b0, busy},      {3'b0, e.busy});
    check(e.tag, "holding", {3'b0, holding},   {3'b0, e.holding});
    check(e.tag, "done",    {3'b0, done},      {3'b0, e.done});
    check(e.tag, "ready",   {3'b0, cmd_ready}, {3'b0, e.ready});
    cmd_valid = 1'b0;
  endtask

  task automatic nop(input string tag, input logic [3:0] eq, input logic eb,
                     input logic eh, input logic edn);
    step(tag, 1'b0, OpStart, 4'd0, 1'b0, 4'd0, eq, eb, eh, edn, 1'b1);
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_op       = OpStart;
    cmd_data     = 4'd0;
    cmd_mode     = 1'b0;
    cmd_prescale = 4'd0;

    nop("reset0", 4'd0, 1'b0, 1'b0, 1'b0);
    nop("reset1", 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // One-shot, limit 3, ps 0.
    step("os_load", 1'b1, OpLoad, 4'd3, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("os_start", 1'b1, OpStart, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) nop($sformatf("os_q%0d", i), 4'(i), 1'b1, 1'b0, 1'b0);
    nop("os_term", 4'd3, 1'b0, 1'b0, 1'b1);
    nop("os_after", 4'd3, 1'b0, 1'b0, 1'b0);
    step("idle_stop", 1'b1, OpStop, 4'd0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);

    // Auto-reload, limit 2, ps 1: q steps every 2 cycles, done every 6.
    step("ar_load", 1'b1, OpLoad, 4'd2, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    step("ar_start", 1'b1, OpStart, 4'd0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 14; k++)
      nop($sformatf("ar_k%0d", k), 4'((k % 6) / 2), 1'b1, 1'b0, (k % 6) == 0);
    step("ar_clear", 1'b1, OpClear, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nop("ar_flush", 4'd0, 1'b0, 1'b0, 1'b0);

    // Limit 15, stop at 5, hold, resume.
    step("hd_load", 1'b1, OpLoad, 4'd15, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("hd_start", 1'b1, OpStart, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) nop($sformatf("hd_q%0d", i), 4'(i), 1'b1, 1'b0, 1'b0);
    step("hd_stop", 1'b1, OpStop, 4'd0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) nop($sformatf("hd_hold%0d", i), 4'd5, 1'b0, 1'b1, 1'b0);
    step("hd_resume", 1'b1, OpStart, 4'd0, 1'b0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 6; i <= 15; i++) nop($sformatf("hd_q%0d", i), 4'(i), 1'b1, 1'b0, 1'b0);
    nop("hd_term", 4'd15, 1'b0, 1'b0, 1'b1);
    nop("hd_after", 4'd15, 1'b0, 1'b0, 1'b0);

    // CLEAR mid-run at q=7.
    step("cl_start", 1'b1, OpStart, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) nop($sformatf("cl_q%0d", i), 4'(i), 1'b1, 1'b0, 1'b0);
    step("cl_clear", 1'b1, OpClear, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nop("cl_idle", 4'd0, 1'b0, 1'b0, 1'b0);
    nop("cl_quiet", 4'd0, 1'b0, 1'b0, 1'b0);

    // LOAD 4 on the tick edge reaching 9: old limit used, next tick terminal.
    step("ld_start", 1'b1, OpStart, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) nop($sformatf("ld_q%0d", i), 4'(i), 1'b1, 1'b0, 1'b0);
    step("ld_load4", 1'b1, OpLoad, 4'd4, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    nop("ld_term", 4'd9, 1'b0, 1'b0, 1'b1);
    nop("ld_after", 4'd9, 1'b0, 1'b0, 1'b0);

    // limit 0, auto-reload, ps 2: done every 3 cycles, q stays 0.
    step("z_load", 1'b1, OpLoad, 4'd0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    step("z_start", 1'b1, OpStart, 4'd0, 1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++)
      nop($sformatf("z_k%0d", k), 4'd0, 1'b1, 1'b0, (k % 3) == 0);

    // Reset on the edge that would have pulsed done; limit returns to 15.
    reset = 1'b1;
    nop("rs_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step("rs_start", 1'b1, OpStart, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 15; i++) nop($sformatf("rs_q%0d", i), 4'(i), 1'b1, 1'b0, 1'b0);
    nop("rs_term", 4'd15, 1'b0, 1'b0, 1'b1);

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard leftover observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
